ook_frame_encoder: RTL and testbench
====================================

Name: ook_frame_encoder

Overview:
- Converts a 3-bit fan command plus a one-cycle start strobe into one complete OOK baseband frame on `ook`.
- `ook` is gated with the 350 MHz LO to drive the antenna.
- Sits directly downstream of the UART command/repeat-timer logic and directly upstream of the antenna gate.
- Runs on the 10 MHz PLL clock.
- Frame time at default parameters is 13.2 ms, which fits inside the 15.84 ms repeat interval.

Parameters:
- CHIP_CYCLES, 2000, clock cycles per chip (200 us at 10 MHz); legal range 2 or more.
- ADDR_BITS, 13, width of the remote address field.
- ADDR, 13'h0A5B, remote address transmitted MSB first.

Ports:
- clk  input  1  10 MHz frame clock.
- reset_n  input  1  asynchronous, active-low reset.
- cmd  input  3  command code; sampled only on an accepted start.
- start_packet  input  1  one-cycle start strobe.
- ook  output  1  registered OOK baseband; 1 = carrier on.
- busy  output  1  high while a frame is being emitted.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, reset_n=0): ook=0, busy=0, done=0, FSM=IDLE, all counters 0. Takes effect immediately, including mid-frame; no partial frame resumes after release.
- Code map (latched at accept): cmd 0→8'h3E, 1→8'h3D, 2→8'h3B, 3→8'h37, 4 (light)→8'h2F.
- Invalid commands: cmd 5/6/7 means no transmission. A start with such a cmd is ignored: busy stays 0, no done.
- Accept condition: start_packet=1 && state==IDLE && cmd<=4, sampled at clock edge T.
  - At edge T: load a shift register with {ADDR, code} (ADDR_BITS+8 = 21 bits).
  - At edge T: busy<=1, ook<=1, enter LEADER.
- start_packet while busy: ignored, no queueing. A cmd change mid-frame has no effect.
- Chip timing: every chip lasts exactly CHIP_CYCLES cycles. A chip counter counts 0..CHIP_CYCLES-1 and advances the chip position on wrap.
- FSM states:
  - IDLE: ook=0.
  - LEADER: 2 chips; ook = 1,0.
  - DATA: 21 symbols, MSB first, 3 chips each. Bit 0 → 1,0,0. Bit 1 → 1,1,0. Shift left after the 3rd chip of each symbol. After symbol 21 go to TRAILER.
  - TRAILER: 1 chip, ook=1. Then go to IDLE: ook<=0, busy<=0, done<=1 for exactly one cycle.
- Frame length: 66 chips. busy is high for exactly 66*CHIP_CYCLES cycles, from edge T through edge T+66*CHIP_CYCLES.
- ook is driven from a register only, so it is glitch-free. It changes only on chip boundaries.
- Back-to-back frames: a start presented in the cycle done=1 is accepted (busy is already 0). The new frame's leader immediately follows.
- done and busy are never high simultaneously.
- Widths:
  - Chip counter: clog2(CHIP_CYCLES) bits.
  - Symbol-chip index: 2 bits, value 0..2 only.
  - Bit index: 5 bits, counting 0..20; wraps to IDLE, never to 0 within DATA.

Test Plan:
1. CHIP_CYCLES=4, reset then idle 20 cycles → ook=0, busy=0, done=0 throughout.
2. cmd=0, start pulse at edge T:
   - busy high for exactly 264 cycles.
   - Sampling ook once per chip gives 1,0, then 3-chip symbols for 0x0A5B (13b) and 0x3E (8b), then 1.
   - done pulses at T+264.
3. cmd=7 and cmd=5 with start → busy stays 0, ook stays 0, no done.
4. cmd=4 start, then a second start at T+100 with cmd=1 → second start ignored; the transmitted code is 0x2F; exactly one done.
5. cmd=3 start, reset_n=0 asserted at T+150 (between edges) → ook/busy drop immediately. After release: idle, no done.
6. cmd=2 start, new start with cmd=1 in the done cycle → second frame begins with no idle chip. Its code is 0x3D. Total busy gap is 1 cycle.

Source files
------------

// File: rtl/ook_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : ook_frame_encoder
//  Brief    : Turns a 3-bit fan command plus a one-cycle start strobe into a
//             complete OOK baseband frame (leader, 21 three-chip symbols,
//             trailer) driven from a register on `ook`.
//  Revision : 1.0 - initial release
// ============================================================================
module ook_frame_encoder #(
    parameter int unsigned          CHIP_CYCLES = 2000,
    parameter int unsigned          ADDR_BITS   = 13,
    parameter logic [ADDR_BITS-1:0] ADDR        = 13'h0A5B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] cmd,
    input  logic       start_packet,
    output logic       ook,
    output logic       busy,
    output logic       done
);

    localparam int unsigned      FRAME_BITS = ADDR_BITS + 8;
    localparam int unsigned      CNT_W      = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CHIP_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST   = 5'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEADER  = 2'd1,
        S_DATA    = 2'd2,
        S_TRAILER = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      chip_cnt_q;
    logic [1:0]            sym_chip_q;   // chip within a symbol (0..2), or leader chip (0..1)
    logic [4:0]            bit_idx_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  ook_q;
    logic                  busy_q;
    logic                  done_q;

    logic [7:0]            code_d;
    logic                  accept_d;
    logic                  chip_end_d;

    // Command code lookup; only consulted when a start is accepted.
    always_comb begin
        code_d = 8'h00;
        case (cmd)
            3'd0:    code_d = 8'h3E;
            3'd1:    code_d = 8'h3D;
            3'd2:    code_d = 8'h3B;
            3'd3:    code_d = 8'h37;
            3'd4:    code_d = 8'h2F;
            default: code_d = 8'h00;
        endcase
    end

    assign accept_d   = start_packet && (cmd <= 3'd4) && (state_q == S_IDLE);
    assign chip_end_d = (chip_cnt_q == CNT_LAST);

    // Frame sequencer: every chip lasts CHIP_CYCLES cycles; ook is updated only at chip boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            chip_cnt_q <= '0;
            sym_chip_q <= 2'd0;
            bit_idx_q  <= 5'd0;
            shift_q    <= '0;
            ook_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state_q != S_IDLE) begin
                chip_cnt_q <= chip_end_d ? '0 : chip_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    ook_q <= 1'b0;
                    if (accept_d) begin
                        shift_q    <= {ADDR, code_d};
                        state_q    <= S_LEADER;
                        busy_q     <= 1'b1;
                        ook_q      <= 1'b1;
                        chip_cnt_q <= '0;
                        sym_chip_q <= 2'd0;
                        bit_idx_q  <= 5'd0;
                    end
                end

                S_LEADER: begin
                    if (chip_end_d) begin
                        if (sym_chip_q == 2'd0) begin
                            sym_chip_q <= 2'd1;
                            ook_q      <= 1'b0;
                        end else begin
                            state_q    <= S_DATA;
                            sym_chip_q <= 2'd0;
                            ook_q      <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (chip_end_d) begin
                        case (sym_chip_q)
                            2'd0: begin
                                sym_chip_q <= 2'd1;
                                ook_q      <= shift_q[FRAME_BITS-1];
                            end
                            2'd1: begin
                                sym_chip_q <= 2'd2;
                                ook_q      <= 1'b0;
                            end
                            default: begin
                                shift_q    <= {shift_q[FRAME_BITS-2:0], 1'b0};
                                sym_chip_q <= 2'd0;
                                ook_q      <= 1'b1;
                                if (bit_idx_q == BIT_LAST) begin
                                    state_q <= S_TRAILER;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 5'd1;
                                end
                            end
                        endcase
                    end
                end

                S_TRAILER: begin
                    if (chip_end_d) begin
                        state_q   <= S_IDLE;
                        bit_idx_q <= 5'd0;
                        ook_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ook  = ook_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ook_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ook_frame_encoder
//  Brief    : Self-checking bench for ook_frame_encoder; a frame-level model
//             (chip list per frame, elapsed-cycle counter) predicts outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ook_frame_encoder;

    localparam int          C      = 4;
    localparam int          NCHIPS = 66;
    localparam logic [12:0] ADDR   = 13'h0A5B;

    logic       clk;
    logic       reset_n;
    logic [2:0] cmd;
    logic       start_packet;
    logic       ook;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_busy;
    bit          m_done;
    int          m_el;
    bit          m_chips [NCHIPS];
    logic [20:0] m_word;

    // observation state
    bit obs_chips [NCHIPS];
    int obs_run;
    int obs_dones;
    int gap_len;
    int last_gap;

    ook_frame_encoder #(
        .CHIP_CYCLES (C),
        .ADDR_BITS   (13),
        .ADDR        (ADDR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd          (cmd),
        .start_packet (start_packet),
        .ook          (ook),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] code_of(input logic [2:0] c);
        logic [7:0] table_v [5] = '{8'h3E, 8'h3D, 8'h3B, 8'h37, 8'h2F};
        return table_v[c];
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_done  = 0;
        m_el    = 0;
        obs_run = 0;
    endtask

    // Advance the model by one clock edge using the inputs held before the edge.
    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (m_busy) begin
            m_el++;
            if (m_el == NCHIPS * C) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (start_packet && cmd <= 3'd4) begin
            m_busy = 1;
            m_el   = 0;
            m_word = {ADDR, code_of(cmd)};
            m_chips[0] = 1;
            m_chips[1] = 0;
            for (int i = 0; i < 21; i++) begin
                m_chips[2 + 3*i] = 1;
                m_chips[3 + 3*i] = m_word[20 - i];
                m_chips[4 + 3*i] = 0;
            end
            m_chips[65] = 1;
        end
    endtask

    task automatic compare();
        logic [20:0] dec;
        bit          exp_ook;
        exp_ook = m_busy ? m_chips[m_el / C] : 1'b0;
        chk("ook",  32'(ook),  32'(exp_ook));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (m_busy && (m_el % C) == C / 2) obs_chips[m_el / C] = ook;
        if (busy === 1'b1) begin
            obs_run++;
            if (gap_len > 0) last_gap = gap_len;
            gap_len = 0;
        end else begin
            gap_len++;
        end
        if (done === 1'b1) begin
            obs_dones++;
            chk("busy_len", obs_run, NCHIPS * C);
            obs_run = 0;
        end
        if (m_done) begin
            dec = '0;
            for (int i = 0; i < 21; i++) dec = {dec[19:0], obs_chips[3 + 3*i]};
            chk("frame_word", 32'(dec), 32'(m_word));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse(input logic [2:0] c);
        cmd          = c;
        start_packet = 1'b1;
        cycle();
        start_packet = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd          = 3'd0;
        start_packet = 1'b0;
        model_reset();
        gap_len  = 0;
        last_gap = 0;
        obs_dones = 0;

        // reset state and idle behaviour
        repeat (3) @(negedge clk);
        chk("rst_ook",  32'(ook),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        idle(20);

        // single frame, cmd 0
        obs_dones = 0;
        pulse(3'd0);
        idle(NCHIPS * C + 10);
        chk("dones_cmd0", obs_dones, 1);

        // invalid commands are ignored
        obs_dones = 0;
        pulse(3'd7);
        idle(10);
        pulse(3'd5);
        idle(10);
        chk("dones_invalid", obs_dones, 0);
        chk("busy_invalid", 32'(busy), 0);

        // start while busy is ignored
        obs_dones = 0;
        pulse(3'd4);
        idle(99);
        pulse(3'd1);
        idle(NCHIPS * C);
        chk("dones_busy_start", obs_dones, 1);

        // asynchronous reset mid-frame
        obs_dones = 0;
        pulse(3'd3);
        idle(149);
        @(posedge clk);
        model_step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_ook",  32'(ook),  0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        compare();
        reset_n = 1'b1;
        idle(NCHIPS * C + 10);
        chk("dones_after_rst", obs_dones, 0);

        // back-to-back frames: restart in the done cycle
        obs_dones = 0;
        pulse(3'd2);
        idle(NCHIPS * C);
        chk("b2b_done_cycle", 32'(done), 1);
        pulse(3'd1);
        idle(NCHIPS * C + 5);
        chk("dones_b2b", obs_dones, 2);
        chk("busy_gap", last_gap, 1);

        // randomized starts and command churn
        for (int n = 0; n < 3000; n++) begin
            start_packet = ($urandom_range(0, 15) == 0);
            cmd          = 3'($urandom_range(0, 7));
            cycle();
        end
        start_packet = 1'b0;
        idle(NCHIPS * C + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
